// File: rtl/l0_pkg.sv
// Shared constants and helpers for the L0 stagger buffer.
// Error-bit indices are only consumed when L0_ERR_EN is defined.
package l0_pkg;

    localparam logic L0_MODE_PARALLEL = 1'b0;
    localparam logic L0_MODE_STAGGER  = 1'b1;

    localparam int unsigned L0_ERR_DROP  = 0;
    localparam int unsigned L0_ERR_EMPTY = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/l0_lane_fifo.sv
// Single-lane FIFO with registered read data and a one-cycle valid pulse per pop.
// Pointers carry an extra wrap bit so full and empty can be told apart.
module l0_lane_fifo
    import l0_pkg::*;
#(
    parameter int unsigned BW    = 4,
    parameter int unsigned DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [BW-1:0] din,
    output logic [BW-1:0] dout,
    output logic          dvalid,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [BW-1:0] mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    // Status is taken before the edge: no rescue of a full write, no bypass to an empty pop.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
        rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dvalid <= pop_ok;
            if (pop_ok) begin
                dout <= mem[rptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/l0_stagger_buf.sv
// L0 activation buffer: one FIFO per array row, popped in parallel or as a skewed wavefront.
// Define L0_ERR_EN to add the sticky o_err status port.
module l0_stagger_buf
    import l0_pkg::*;
#(
    parameter int unsigned ROW   = 8,
    parameter int unsigned BW    = 4,
    parameter int unsigned DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROW*BW-1:0] in,
    input  logic              wr,
    input  logic              rd,
    input  logic              mode,
    output logic [ROW*BW-1:0] out,
    output logic [ROW-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty
`ifdef L0_ERR_EN
    ,
    output logic [1:0]        o_err
`endif
);

    logic           act_mode_q, act_mode_d;
    logic [ROW-2:0] tok_q, tok_d;
    logic [ROW-1:0] pop_req;
    logic [ROW-1:0] lane_full;
    logic [ROW-1:0] lane_empty;
    logic           stagger;
    logic           wr_ok;

    assign stagger = (act_mode_q == L0_MODE_STAGGER);
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign o_empty = &lane_empty;
    assign wr_ok   = wr & o_ready;

    // Mode only switches while the skew chain is idle, so a wavefront never changes shape.
    always_comb begin
        tok_d    = '0;
        tok_d[0] = rd & stagger;
        for (int k = 1; k < int'(ROW) - 1; k++) begin
            tok_d[k] = tok_q[k-1];
        end
        act_mode_d = (tok_q == '0) ? mode : act_mode_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok_q      <= '0;
            act_mode_q <= L0_MODE_PARALLEL;
        end else begin
            tok_q      <= tok_d;
            act_mode_q <= act_mode_d;
        end
    end

    for (genvar g = 0; g < ROW; g++) begin : g_lane
        // In-flight tokens are always honoured, even after the mode has gone back to parallel.
        if (g == 0) begin : g_head
            assign pop_req[g] = rd;
        end else begin : g_tail
            assign pop_req[g] = (rd & ~stagger) | tok_q[g-1];
        end

        l0_lane_fifo #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push   (wr_ok),
            .pop    (pop_req[g]),
            .din    (in[BW*g +: BW]),
            .dout   (out[BW*g +: BW]),
            .dvalid (o_valid[g]),
            .full   (lane_full[g]),
            .empty  (lane_empty[g])
        );
    end

`ifdef L0_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (wr & o_full) begin
            err_d[L0_ERR_DROP] = 1'b1;
        end
        if (|(pop_req & lane_empty)) begin
            err_d[L0_ERR_EMPTY] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_l0_stagger_buf.sv
// Scoreboard bench for l0_stagger_buf: a queue-based model schedules pops per lane and a
// negedge monitor checks valid, data and status against it.
module tb_l0_stagger_buf;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ROW*BW-1:0] in = '0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic              mode = 1'b0;
    logic [ROW*BW-1:0] out;
    logic [ROW-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
`ifdef L0_ERR_EN
    logic [1:0]        o_err;
`endif

    always #5 clk = ~clk;

    l0_stagger_buf #(
        .ROW   (ROW),
        .BW    (BW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .mode    (mode),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_empty (o_empty)
`ifdef L0_ERR_EN
        ,
        .o_err   (o_err)
`endif
    );

    typedef struct packed {
        logic [31:0]   e;
        logic [BW-1:0] d;
    } exp_t;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    logic [BW-1:0]  mq [ROW][$];
    exp_t           eq [ROW][$];
    logic [ROW-1:0] sched [int];
    logic [BW-1:0]  last [ROW];
    logic           m_act;
    int             last_stag;
    logic [1:0]     merr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_n);
        end
    endtask

    function automatic logic [ROW*BW-1:0] word(input int k);
        logic [ROW*BW-1:0] w;
        for (int i = 0; i < ROW; i++) begin
            w[BW*i +: BW] = BW'(i + 1 + k);
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ROW; i++) begin
            mq[i].delete();
            eq[i].delete();
            last[i] = '0;
        end
        sched.delete();
        m_act     = 1'b0;
        last_stag = -1000;
        merr      = '0;
    endtask

    // One clock edge of the reference: staggered rd at e wants lane i at edge e+i.
    task automatic model_edge(input logic w, input logic r, input logic m,
                              input logic [ROW*BW-1:0] d);
        int             e;
        logic           full;
        logic           busy;
        logic [ROW-1:0] req;
        logic [ROW-1:0] tmp;
        exp_t           x;
        edge_n++;
        e = edge_n;
        full = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            if (mq[i].size() == DEPTH) full = 1'b1;
        end
        if (r) begin
            for (int i = 0; i < ROW; i++) begin
                int t;
                t = m_act ? e + i : e;
                tmp = sched.exists(t) ? sched[t] : '0;
                tmp[i] = 1'b1;
                sched[t] = tmp;
            end
        end
        busy = (e - last_stag) < ROW;
        if (r && m_act) last_stag = e;
        req = '0;
        if (sched.exists(e)) begin
            req = sched[e];
            sched.delete(e);
        end
        for (int i = 0; i < ROW; i++) begin
            if (req[i]) begin
                if (mq[i].size() > 0) begin
                    x.e = 32'(e);
                    x.d = mq[i].pop_front();
                    eq[i].push_back(x);
                end else begin
                    merr[1] = 1'b1;
                end
            end
        end
        if (w) begin
            if (full) begin
                merr[0] = 1'b1;
            end else begin
                for (int i = 0; i < ROW; i++) mq[i].push_back(d[BW*i +: BW]);
            end
        end
        if (!busy) m_act = m;
    endtask

    task automatic step(input logic w, input logic r, input logic m,
                        input logic [ROW*BW-1:0] d);
        wr   = w;
        rd   = r;
        mode = m;
        in   = d;
        @(posedge clk);
        model_edge(w, r, m, d);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        model_clear();
        #1;
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_full", 64'(o_full), 64'd0);
`ifdef L0_ERR_EN
        chk("rst_err", 64'(o_err), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        logic due;
        logic m_full;
        logic m_empty;
        m_full  = 1'b0;
        m_empty = 1'b1;
        for (int i = 0; i < ROW; i++) begin
            due = (eq[i].size() > 0) && (eq[i][0].e == 32'(edge_n));
            chk($sformatf("valid[%0d]", i), 64'(o_valid[i]), 64'(due));
            if (due) last[i] = eq[i].pop_front().d;
            chk($sformatf("out[%0d]", i), 64'(out[BW*i +: BW]), 64'(last[i]));
            if (mq[i].size() == DEPTH) m_full = 1'b1;
            if (mq[i].size() != 0) m_empty = 1'b0;
        end
        chk("o_full", 64'(o_full), 64'(m_full));
        chk("o_ready", 64'(o_ready), 64'(!m_full));
        chk("o_empty", 64'(o_empty), 64'(m_empty));
`ifdef L0_ERR_EN
        chk("o_err", 64'(o_err), 64'(merr));
`endif
    end

    initial begin
        logic m;
        int   wp;
        int   rp;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);

        // Parallel: three words then three reads.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, word(k));
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, '0);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);

        // Staggered: one word, one read.
        repeat (2) step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, word(5));
        step(1'b0, 1'b1, 1'b1, '0);
        repeat (ROW + 1) step(1'b0, 1'b0, 1'b1, '0);

        // Full boundary: fill, dropped write with read, accepted write, drain.
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 1'b0, $urandom());
        step(1'b1, 1'b1, 1'b0, $urandom());
        step(1'b1, 1'b0, 1'b0, $urandom());
        repeat (DEPTH + 2) step(1'b0, 1'b1, 1'b0, '0);

        // Empty boundary: read on empty, write+read on empty, then read.
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, word(9));
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);

        // Mode flips back to parallel two cycles into a staggered wavefront.
        repeat (2) step(1'b0, 1'b0, 1'b1, '0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, word(k + 3));
        step(1'b0, 1'b1, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        repeat (ROW) step(1'b0, 1'b0, 1'b0, '0);
        repeat (2) step(1'b0, 1'b1, 1'b0, '0);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);

        // Random traffic: filling phase, reset mid-run, draining phase.
        m = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            wp = (n < 1500) ? 70 : 35;
            rp = (n < 1500) ? 40 : 70;
            if ($urandom_range(0, 19) == 0) m = ~m;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, m, $urandom());
        end
        repeat (ROW + 2) step(1'b0, 1'b0, m, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
